sdram_loader: RTL
=================

// Module: sdram_loader
// PURPOSE
//  Initiator-side client of the sdram_bus req/ack toggle protocol. It takes a byte stream
//  (from MCU/SPI image upload) and packs it little-endian into 16-bit words. Each word is
//  written at sequential SDRAM word addresses through one sdram channel (ch0/ch1).
//  Used to load PRG/CHR images before the cartridge core starts.
// PARAMETERS
//  ADDR_BITS  24  SDRAM word-address width; must match the sdram_bus instance
// PORTS
//  clk         in   1          system clock, same domain as sdram channel logic
//  rst         in   1          synchronous, active-high reset
//  cmd_start   in   1          1-cycle pulse: begin a load; ignored while busy=1
//  cmd_addr    in   ADDR_BITS  first word address, sampled on cmd_start
//  cmd_len     in   ADDR_BITS+1  byte count, sampled on cmd_start; 0 is legal
//  s_data      in   8          stream byte
//  s_valid     in   1          stream byte valid
//  s_ready     out  1          byte accepted when s_valid&&s_ready at posedge clk
//  busy        out  1          load in progress
//  done        out  1          1-cycle pulse when the load completes
//  error       out  1          sticky verify mismatch; cleared on cmd_start (see CONFIGURATION)
//  bus         sdram_bus       initiator side: drives req, we, address, data_write; reads ack, data_read
// BEHAVIOUR
//  - Reset values: s_ready=0, busy=0, done=0, error=0, bus.req=0, bus.we=0,
//    bus.address=0, bus.data_write=0. The controller's ack also resets to 0.
//  - Protocol: a transaction starts when req is toggled, with we/address/data_write valid
//    in the same cycle. Hold these until ack==req is sampled. Then the transaction is
//    complete and data_read is valid for reads. Only one transaction is outstanding at a time.
//  - States: IDLE -> COLLECT -> WRITE -> WAIT_W -> [VERIFY -> WAIT_R] -> COLLECT | FINISH -> IDLE.
//  - IDLE: busy=0.
//    - On cmd_start: latch addr/len, busy=1, error=0.
//    - If len==0, go to FINISH (done pulses on the next cycle; no bus traffic).
//    - Otherwise go to COLLECT.
//  - COLLECT: s_ready=1.
//    - The first byte goes to word[7:0] and the second to word[15:8].
//    - After 2 bytes, or after 1 byte when it is the final odd byte (upper byte = 8'h00),
//      go to WRITE.
//    - s_ready drops the cycle after the word completes.
//  - WRITE: toggle req with we=1, address=cur_addr, data_write=word. Go to WAIT_W.
//  - WAIT_W: on ack==req, cur_addr += 1.
//    - The address wraps modulo 2^ADDR_BITS: 'hFFFFFF+1 -> 0.
//    - Decrement the remaining count by the bytes in this word.
//    - If remaining==0 go to FINISH, else go to COLLECT (or VERIFY if enabled).
//  - FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
//  - Throughput: at least 2 stream cycles plus the controller latency per word. No byte is
//    dropped or duplicated under arbitrary s_valid gaps.
//  - cmd_start while busy: ignored, with no effect on the current load.
//  - Reset mid-operation: the load is aborted immediately, all outputs take their reset
//    values, and no done pulse is produced.
// CONFIGURATION
//  SDRAM_LOADER_VERIFY_EN defined:
//    - After each write ack, VERIFY toggles req with we=0 at the same (pre-increment) address.
//    - WAIT_R compares data_read to the written word. On mismatch, error=1 (sticky until the
//      next cmd_start) and the load continues.
//    - The address increment and the remaining count are applied after the read ack.
//  Not defined: the VERIFY/WAIT_R states are absent and error is tied to 0.
// TESTING
//  - Reset: hold rst 3 cycles -> all outputs 0, req=0; no bus activity until cmd_start.
//  - Even load: addr=0x10, len=4, bytes F8,F7,F8,A7 -> writes [0x10]=F7F8, [0x11]=A7F8.
//    done pulses once after the second ack; busy falls the next cycle.
//  - Odd length with stalls: addr=0, len=3, bytes 11,22,33 with random s_valid gaps
//    -> [0]=2211, [1]=0033; exactly 3 s_ready handshakes.
//  - Wrap and zero: addr='hFFFFFF, len=4 -> words at 'hFFFFFF then 0.
//    len=0 -> done one cycle after the start pulse, no req toggle.
//  - Verify (VERIFY_EN): the model corrupts the read of address 0x20 -> error=1 and
//    loading completes. A new cmd_start clears error.
//  - Abort: assert rst mid-WAIT_W -> outputs reset next cycle and no done pulse.
//    A new load with len=2 then succeeds and the readback matches.

Source files
------------

// File: rtl/sdram_loader_if.sv
// sdram_bus req/ack toggle channel: a transaction is open while req != ack.
// Initiator holds we/address/data_write until ack matches req; data_read valid thereafter.
interface sdram_bus #(
    parameter int ADDR_BITS = 24
);
    logic                 req;
    logic                 ack;
    logic                 we;
    logic [ADDR_BITS-1:0] address;
    logic [15:0]          data_write;
    logic [15:0]          data_read;

    modport master (
        output req, we, address, data_write,
        input  ack, data_read
    );

    modport slave (
        input  req, we, address, data_write,
        output ack, data_read
    );
endinterface

// File: rtl/sdram_loader.sv
// Packs a byte stream little-endian into 16-bit words written at sequential SDRAM addresses; one bus op in flight,
// s_ready only in COLLECT so the stream stalls during bus ops. SDRAM_LOADER_VERIFY_EN adds read-back verify per word.
module sdram_loader #(
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_start,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [ADDR_BITS:0]   cmd_len,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    sdram_bus.master             bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FINISH,
        S_COLLECT,
        S_WRITE,
        S_WAIT_W
`ifdef SDRAM_LOADER_VERIFY_EN
        ,
        S_VERIFY,
        S_WAIT_R
`endif
    } state_t;

    localparam logic [ADDR_BITS:0]   LEN_ZERO = '0;
    localparam logic [ADDR_BITS:0]   LEN_ONE  = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0]   LEN_TWO  = (ADDR_BITS+1)'(2);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_BITS:0]   remaining_q, remaining_d;
    logic [15:0]          word_q, word_d;
    logic                 have_lo_q, have_lo_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_out_q, addr_out_d;
    logic [15:0]          wdata_q, wdata_d;
    logic                 step_done;
    logic [ADDR_BITS:0]   word_bytes;
`ifdef SDRAM_LOADER_VERIFY_EN
    logic                 error_q, error_d;
`endif

    // A word holds one byte only when it carries the last byte of an odd-length load.
    assign word_bytes = (remaining_q == LEN_ONE) ? LEN_ONE : LEN_TWO;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            have_lo_q   <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_out_q  <= '0;
            wdata_q     <= '0;
`ifdef SDRAM_LOADER_VERIFY_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            have_lo_q   <= have_lo_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_out_q  <= addr_out_d;
            wdata_q     <= wdata_d;
`ifdef SDRAM_LOADER_VERIFY_EN
            error_q     <= error_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        word_d      = word_q;
        have_lo_d   = have_lo_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_out_d  = addr_out_q;
        wdata_d     = wdata_q;
        step_done   = 1'b0;
`ifdef SDRAM_LOADER_VERIFY_EN
        error_d     = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    have_lo_d   = 1'b0;
`ifdef SDRAM_LOADER_VERIFY_EN
                    error_d     = 1'b0;
`endif
                    state_d     = (cmd_len == LEN_ZERO) ? S_FINISH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (s_valid) begin
                    if (!have_lo_q) begin
                        word_d = {8'h00, s_data};
                        if (remaining_q == LEN_ONE) begin
                            state_d = S_WRITE;
                        end else begin
                            have_lo_d = 1'b1;
                        end
                    end else begin
                        word_d[15:8] = s_data;
                        have_lo_d    = 1'b0;
                        state_d      = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                req_d      = ~req_q;
                we_d       = 1'b1;
                addr_out_d = cur_addr_q;
                wdata_d    = word_q;
                state_d    = S_WAIT_W;
            end
            S_WAIT_W: begin
                if (bus.ack == req_q) begin
`ifdef SDRAM_LOADER_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    step_done = 1'b1;
`endif
                end
            end
`ifdef SDRAM_LOADER_VERIFY_EN
            S_VERIFY: begin
                req_d      = ~req_q;
                we_d       = 1'b0;
                addr_out_d = cur_addr_q;
                state_d    = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (bus.ack == req_q) begin
                    if (bus.data_read != word_q) begin
                        error_d = 1'b1;
                    end
                    step_done = 1'b1;
                end
            end
`endif
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (step_done) begin
            cur_addr_d  = cur_addr_q + ADDR_ONE;
            remaining_d = remaining_q - word_bytes;
            state_d     = (remaining_q == word_bytes) ? S_FINISH : S_COLLECT;
        end
    end

    always_comb begin
        s_ready = (state_q == S_COLLECT);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_FINISH);
`ifdef SDRAM_LOADER_VERIFY_EN
        error   = error_q;
`else
        error   = 1'b0;
`endif
    end

    assign bus.req        = req_q;
    assign bus.we         = we_q;
    assign bus.address    = addr_out_q;
    assign bus.data_write = wdata_q;

endmodule
